cfg_timer_pwm: RTL and testbench



---
 rtl/cfg_timer_pkg.sv | 42 ++++
 rtl/timer_prescaler.sv | 37 +++
 rtl/cfg_timer_pwm.sv | 215 +++++++++++++++++++++
 tb/tb_cfg_timer_pwm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_timer_pkg.sv
// ---------------------------------------------------------------------------
// cfg_timer_pkg : register map indices, bit positions and FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cfg_timer_pkg;

  // Config register indices
  localparam int CTRL_IDX     = 0;
  localparam int PRESCALE_IDX = 1;
  localparam int PERIOD_IDX   = 2;
  localparam int DUTY_IDX     = 3;
  localparam int IRQ_MASK_IDX = 4;

  // Status register indices
  localparam int COUNT_IDX    = 0;
  localparam int FLAGS_IDX    = 1;
  localparam int WRAP_CNT_IDX = 2;
  localparam int CAP_VAL_IDX  = 3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_INV_BIT     = 2;
  localparam int CTRL_CLR_BIT     = 3;

  // FLAGS bit positions
  localparam int FLAG_WRAP_BIT    = 0;
  localparam int FLAG_CMP_BIT     = 1;
  localparam int FLAG_RUNNING_BIT = 2;
  localparam int FLAG_CAP_BIT     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler : counts 0..prescale, pulses tick on the terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_prescaler #(
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 clear,
  input  logic [REG_WIDTH-1:0] prescale,
  output logic                 tick
);

  logic [REG_WIDTH-1:0] pre;

  // >= keeps the divider from running away if prescale is lowered below pre
  assign tick = !clear && (pre >= prescale);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pre <= '0;
    end else if (ena) begin
      if (clear || tick) begin
        pre <= '0;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfg_timer_pwm.sv
// ---------------------------------------------------------------------------
// cfg_timer_pwm : prescaled timer with double-buffered PWM, flags and irq
// Optional capture input enabled by macro CFG_TIMER_CAPTURE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfg_timer_pwm
  import cfg_timer_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  input  logic                            capture_in,
  output logic                            pwm_out,
  output logic                            irq
);

  logic [REG_WIDTH-1:0] ctrl, prescale, period, duty, irq_mask;

  assign ctrl     = config_regs[CTRL_IDX*REG_WIDTH     +: REG_WIDTH];
  assign prescale = config_regs[PRESCALE_IDX*REG_WIDTH +: REG_WIDTH];
  assign period   = config_regs[PERIOD_IDX*REG_WIDTH   +: REG_WIDTH];
  assign duty     = config_regs[DUTY_IDX*REG_WIDTH     +: REG_WIDTH];
  assign irq_mask = config_regs[IRQ_MASK_IDX*REG_WIDTH +: REG_WIDTH];

  logic en_bit, oneshot_bit, inv_bit, clr_bit;
  assign en_bit      = ctrl[CTRL_EN_BIT];
  assign oneshot_bit = ctrl[CTRL_ONESHOT_BIT];
  assign inv_bit     = ctrl[CTRL_INV_BIT];
  assign clr_bit     = ctrl[CTRL_CLR_BIT];

  // Unused config bits and registers are intentionally ignored
  logic unused_inputs;
  assign unused_inputs = &{1'b0, config_regs, capture_in};

  state_t               state, state_nx;
  logic                 en_q, clr_q;
  logic                 en_rise, clr_rise;
  logic [REG_WIDTH-1:0] cnt, per_sh, duty_sh, wrap_cnt, cap_val;
  logic                 flag_wrap, flag_cmp, flag_cap;
  logic                 tick;
  logic                 load_sh, cnt_clr, cnt_inc, wrap_ev, cmp_ev, cap_ev;

  assign en_rise  = en_bit & ~en_q;
  assign clr_rise = clr_bit & ~clr_q;

  timer_prescaler #(
    .REG_WIDTH (REG_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .clear    (state != RUN),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load_sh  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    wrap_ev  = 1'b0;
    cmp_ev   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (en_rise) begin
          state_nx = RUN;
          load_sh  = 1'b1;
        end
      end
      RUN: begin
        // Dropping EN abandons the period without raising any events
        if (!en_bit) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (tick) begin
          cmp_ev = (cnt == duty_sh);
          if (cnt == per_sh) begin
            wrap_ev = 1'b1;
            load_sh = 1'b1;
            cnt_clr = 1'b1;
            if (oneshot_bit) begin
              state_nx = DONE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        if (!en_bit) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      cnt       <= '0;
      per_sh    <= '0;
      duty_sh   <= '0;
      wrap_cnt  <= '0;
      flag_wrap <= 1'b0;
      flag_cmp  <= 1'b0;
      pwm_out   <= 1'b0;
      irq       <= 1'b0;
    end else if (ena) begin
      en_q  <= en_bit;
      clr_q <= clr_bit;

      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end

      if (load_sh) begin
        per_sh  <= period;
        duty_sh <= duty;
      end

      // A set in the same cycle as a clear takes priority
      if (wrap_ev) begin
        flag_wrap <= 1'b1;
      end else if (clr_rise) begin
        flag_wrap <= 1'b0;
      end

      if (cmp_ev) begin
        flag_cmp <= 1'b1;
      end else if (clr_rise) begin
        flag_cmp <= 1'b0;
      end

      if (clr_rise) begin
        wrap_cnt <= wrap_ev ? {{(REG_WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if (wrap_ev) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end

      pwm_out <= (state == RUN) ? ((cnt < duty_sh) ^ inv_bit) : inv_bit;
      irq     <= |({flag_cap, 1'b0, flag_cmp, flag_wrap} & irq_mask[3:0]);
    end
  end

`ifdef CFG_TIMER_CAPTURE_EN
  logic cap_s1, cap_s2, cap_s3;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cap_s1   <= 1'b0;
      cap_s2   <= 1'b0;
      cap_s3   <= 1'b0;
      cap_val  <= '0;
      flag_cap <= 1'b0;
    end else if (ena) begin
      cap_s1 <= capture_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
      if (cap_ev) begin
        cap_val <= cnt;
      end
      if (cap_ev) begin
        flag_cap <= 1'b1;
      end else if (clr_rise) begin
        flag_cap <= 1'b0;
      end
    end
  end

  assign cap_ev = cap_s2 & ~cap_s3;
`else
  assign cap_ev   = 1'b0;
  assign cap_val  = '0;
  assign flag_cap = 1'b0;
`endif

  always_comb begin
    status_regs = '0;
    status_regs[COUNT_IDX*REG_WIDTH    +: REG_WIDTH] = cnt;
    status_regs[WRAP_CNT_IDX*REG_WIDTH +: REG_WIDTH] = wrap_cnt;
    status_regs[CAP_VAL_IDX*REG_WIDTH  +: REG_WIDTH] = cap_val;
    status_regs[FLAGS_IDX*REG_WIDTH + FLAG_WRAP_BIT]    = flag_wrap;
    status_regs[FLAGS_IDX*REG_WIDTH + FLAG_CMP_BIT]     = flag_cmp;
    status_regs[FLAGS_IDX*REG_WIDTH + FLAG_RUNNING_BIT] = (state == RUN);
    status_regs[FLAGS_IDX*REG_WIDTH + FLAG_CAP_BIT]     = flag_cap;
  end

endmodule

`default_nettype wire

// File: tb/tb_cfg_timer_pwm.sv
// ---------------------------------------------------------------------------
// tb_cfg_timer_pwm : directed self-checking bench for cfg_timer_pwm
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cfg_timer_pwm;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic        capture_in;
  logic        pwm_out;
  logic        irq;

  logic [7:0]  cfg [8];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) config_regs[i*8 +: 8] = cfg[i];
  end

  cfg_timer_pwm dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .config_regs (config_regs),
    .status_regs (status_regs),
    .capture_in  (capture_in),
    .pwm_out     (pwm_out),
    .irq         (irq)
  );

  function automatic logic [7:0] st(input int idx);
    return status_regs[idx*8 +: 8];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] pat;
    logic [7:0] inv_pat;
    pat     = 4'b0011;
    inv_pat = 8'b1100_1111;
    for (int i = 0; i < 8; i++) cfg[i] = 8'h00;
    rstb       = 1'b0;
    ena        = 1'b1;
    capture_in = 1'b0;

    // Reset state
    step(2);
    chk("rst_count", st(0), 8'h00);
    chk("rst_flags", st(1), 8'h00);
    chk("rst_wcnt",  st(2), 8'h00);
    chk("rst_pwm",   pwm_out, 1'b0);
    chk("rst_irq",   irq, 1'b0);
    rstb = 1'b1;
    step(1);

    // PRESCALE=0 PERIOD=3 DUTY=2: pwm 1,1,0,0
    cfg[1] = 8'd0; cfg[2] = 8'd3; cfg[3] = 8'd2; cfg[0] = 8'h01;
    step(1);
    chk("start_flags", st(1), 8'h04);
    chk("start_cnt",   st(0), 8'h00);
    chk("start_pwm",   pwm_out, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("p1_cnt", st(0), k % 4);
      chk("p1_pwm", pwm_out, pat[(k-1)%4]);
      if (k == 3) chk("p1_cmp_no_wrap", st(1), 8'h06);
      if (k == 4) chk("p1_wcnt1", st(2), 8'd1);
    end
    chk("p1_wcnt2", st(2), 8'd2);
    chk("p1_flags", st(1), 8'h07);

    // Mid-run DUTY change waits for wrap
    cfg[3] = 8'd0;
    for (int k = 9; k <= 16; k++) begin
      step(1);
      chk("duty_chg_pwm", pwm_out, (k <= 12) ? pat[(k-1)%4] : 1'b0);
    end
    cfg[0] = 8'h05; cfg[3] = 8'd2;
    for (int k = 17; k <= 24; k++) begin
      step(1);
      chk("inv_pwm", pwm_out, inv_pat[k-17]);
    end

    // Disable -> IDLE
    cfg[0] = 8'h00;
    step(1);
    chk("dis_running", st(1) & 8'h04, 8'h00);
    chk("dis_cnt", st(0), 8'h00);
    step(1);
    chk("dis_pwm", pwm_out, 1'b0);
    cfg[0] = 8'h08;
    step(1);
    chk("clr_flags", st(1), 8'h00);
    chk("clr_wcnt",  st(2), 8'h00);

    // PRESCALE=2 PERIOD=1
    cfg[1] = 8'd2; cfg[2] = 8'd1; cfg[3] = 8'd1; cfg[0] = 8'h01;
    step(1);
    for (int j = 1; j <= 12; j++) begin
      step(1);
      chk("pre_cnt", st(0), (j / 3) % 2);
      if (j == 6) chk("pre_wcnt1", st(2), 8'd1);
    end
    chk("pre_wcnt2", st(2), 8'd2);

    // ONESHOT=1 PERIOD=5 INV=1
    cfg[0] = 8'h08;
    step(1);
    chk("os_clr_wcnt", st(2), 8'h00);
    cfg[1] = 8'd0; cfg[2] = 8'd5; cfg[3] = 8'd2; cfg[0] = 8'h07;
    step(1);
    chk("os_idle_pwm", pwm_out, 1'b1);
    step(2);
    chk("os_run_pwm", pwm_out, 1'b0);
    chk("os_run_cnt", st(0), 8'd2);
    step(4);
    chk("os_done_cnt",  st(0), 8'd0);
    chk("os_done_run",  st(1) & 8'h04, 8'h00);
    chk("os_done_wcnt", st(2), 8'd1);
    step(4);
    chk("os_hold_cnt",   st(0), 8'd0);
    chk("os_hold_wcnt",  st(2), 8'd1);
    chk("os_hold_pwm",   pwm_out, 1'b1);
    chk("os_hold_flags", st(1), 8'h03);
    cfg[0] = 8'h06;
    step(1);
    chk("os_idle_run", st(1) & 8'h04, 8'h00);
    cfg[0] = 8'h07;
    step(1);
    chk("os_rearm_run", st(1) & 8'h04, 8'h04);
    step(2);
    chk("os_rearm_cnt", st(0), 8'd2);

    // IRQ on WRAP, CLR behaviour
    cfg[0] = 8'h08; cfg[4] = 8'h01;
    step(2);
    chk("irq_idle", irq, 1'b0);
    cfg[1] = 8'd0; cfg[2] = 8'd3; cfg[3] = 8'd2; cfg[0] = 8'h01;
    step(1);
    step(4);
    chk("irq_wrap_flag", st(1) & 8'h01, 8'h01);
    chk("irq_lag", irq, 1'b0);
    step(1);
    chk("irq_set", irq, 1'b1);
    cfg[0] = 8'h09;
    step(1);
    chk("clr_wrap_flag", st(1) & 8'h01, 8'h00);
    chk("clr_irq_lag", irq, 1'b1);
    cfg[0] = 8'h01;
    step(1);
    chk("clr_irq", irq, 1'b0);
    cfg[0] = 8'h09;
    step(1);
    chk("clr_vs_wrap", st(1) & 8'h01, 8'h01);

    // WRAP_CNT rollover with a wrap every cycle
    cfg[0] = 8'h00;
    step(1);
    cfg[0] = 8'h08;
    step(1);
    chk("roll_clr", st(2), 8'h00);
    cfg[2] = 8'd0; cfg[0] = 8'h01;
    step(1);
    step(255);
    chk("roll_255", st(2), 8'd255);
    step(1);
    chk("roll_0", st(2), 8'd0);
    chk("roll_flag", st(1) & 8'h01, 8'h01);

    // Capture and ena hold
    cfg[0] = 8'h00;
    step(1);
    cfg[0] = 8'h08;
    step(1);
    cfg[2] = 8'd7; cfg[4] = 8'h00; cfg[0] = 8'h01;
    step(1);
    step(1);
    capture_in = 1'b1;
    step(2);
    capture_in = 1'b0;
    step(3);
    chk("cap_cnt", st(0), 8'd6);
`ifdef CFG_TIMER_CAPTURE_EN
    chk("cap_val",  st(3), 8'd3);
    chk("cap_flag", st(1) & 8'h08, 8'h08);
`else
    chk("cap_val",  st(3), 8'd0);
    chk("cap_flag", st(1) & 8'h08, 8'h00);
`endif
    chk("st1_upper", st(1) & 8'hF0, 8'h00);
    for (int i = 4; i < 8; i++) chk("st_unused", st(i), 8'h00);
    ena = 1'b0;
    step(5);
    chk("ena_hold_cnt", st(0), 8'd6);
    chk("ena_hold_pwm", pwm_out, 1'b0);
    ena = 1'b1;
    step(1);
    chk("ena_resume_cnt", st(0), 8'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
